// File: rtl/kbd_event_arbiter_if.sv
// Event-path bundle between the requesters and kbd_event_arbiter.
// Optional drop-counter signals exist only when KBD_ARB_DROP_CNT_EN is defined.
interface kbd_event_arbiter_if #(
    parameter int W = 17
);
    logic [W-1:0] spi_data;
    logic         spi_valid;
    logic [W-1:0] nat_data;
    logic         nat_valid;
    logic         flush;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_src;
    logic         spi_drop;
    logic         nat_drop;
`ifdef KBD_ARB_DROP_CNT_EN
    logic [7:0]   spi_drop_cnt;
    logic [7:0]   nat_drop_cnt;
`endif

    modport master (
        output spi_data, spi_valid, nat_data, nat_valid, flush,
        input  out_data, out_valid, out_src, spi_drop, nat_drop
`ifdef KBD_ARB_DROP_CNT_EN
        , input spi_drop_cnt, nat_drop_cnt
`endif
    );

    modport slave (
        input  spi_data, spi_valid, nat_data, nat_valid, flush,
        output out_data, out_valid, out_src, spi_drop, nat_drop
`ifdef KBD_ARB_DROP_CNT_EN
        , output spi_drop_cnt, nat_drop_cnt
`endif
    );
endinterface

// File: rtl/kbd_event_arbiter.sv
// Two-source keyboard/mouse event arbiter: per-source FIFOs, round-robin grant, MIN_GAP pacing.
// Define KBD_ARB_DROP_CNT_EN to add saturating per-source drop counters.
module kbd_event_arbiter #(
    parameter int DEPTH   = 4,
    parameter int MIN_GAP = 64,
    parameter int W       = 17
) (
    input  logic               clk27,
    input  logic               reset,
    kbd_event_arbiter_if.slave bus
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int GAP_W = (MIN_GAP > 2) ? $clog2(MIN_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(MIN_GAP - 2);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_GAP  = 1'b1;

    // Source index doubles as the out_src encoding.
    localparam logic SRC_NAT = 1'b0;
    localparam logic SRC_SPI = 1'b1;

    logic [1:0]   push_valid;
    logic [W-1:0] push_data [2];
    logic [1:0]   push_ok;
    logic [1:0]   pop;
    logic [1:0]   drop;
    logic [1:0]   non_empty;
    logic [W-1:0] head_word [2];
`ifdef KBD_ARB_DROP_CNT_EN
    logic [7:0]   drop_cnt [2];
`endif

    logic [0:0]       state_reg;
    logic [GAP_W-1:0] gap_cnt_reg;
    logic             out_valid_reg;
    logic             out_src_reg;
    logic             last_grant_reg;
    logic             grant_valid;
    logic             grant_src;
    logic             block_push;

    assign push_valid   = {bus.spi_valid, bus.nat_valid};
    assign push_data[0] = bus.nat_data;
    assign push_data[1] = bus.spi_data;

    // Pushes during reset or flush vanish silently: no storage, no drop pulse.
    assign block_push = reset | bus.flush;

    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
        logic [W-1:0]     mem [DEPTH];
        logic [PTR_W-1:0] wr_ptr_reg;
        logic [PTR_W-1:0] rd_ptr_reg;
        logic [CNT_W-1:0] count_reg;
        logic [W-1:0]     rd_word_reg;

        assign non_empty[gi] = (count_reg != '0);
        // A full FIFO still accepts when it is popped in the same cycle.
        assign push_ok[gi]   = push_valid[gi] && !block_push &&
                               ((count_reg != CNT_FULL) || pop[gi]);
        assign drop[gi]      = push_valid[gi] && !block_push && !push_ok[gi];
        assign head_word[gi] = rd_word_reg;

        always_ff @(posedge clk27) begin
            if (push_ok[gi]) begin
                mem[wr_ptr_reg] <= push_data[gi];
            end
        end

        // Read register only moves on a pop of this source, so it holds the
        // last word granted from here until this source is granted again.
        always_ff @(posedge clk27) begin
            if (reset) begin
                rd_word_reg <= '0;
            end else if (pop[gi]) begin
                rd_word_reg <= mem[rd_ptr_reg];
            end
        end

        always_ff @(posedge clk27) begin
            if (reset || bus.flush) begin
                wr_ptr_reg <= '0;
                rd_ptr_reg <= '0;
                count_reg  <= '0;
            end else begin
                if (push_ok[gi]) begin
                    wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
                end
                if (pop[gi]) begin
                    rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
                end
                case ({push_ok[gi], pop[gi]})
                    2'b10:   count_reg <= count_reg + CNT_W'(1);
                    2'b01:   count_reg <= count_reg - CNT_W'(1);
                    default: count_reg <= count_reg;
                endcase
            end
        end

`ifdef KBD_ARB_DROP_CNT_EN
        logic [7:0] drop_cnt_reg;

        always_ff @(posedge clk27) begin
            if (reset || bus.flush) begin
                drop_cnt_reg <= '0;
            end else if (drop[gi] && (drop_cnt_reg != 8'hFF)) begin
                drop_cnt_reg <= drop_cnt_reg + 8'd1;
            end
        end

        assign drop_cnt[gi] = drop_cnt_reg;
`endif
    end

    // Grant decision uses registered counts, so a word pushed this cycle
    // cannot be granted before the next one.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = SRC_NAT;
        if ((state_reg == ST_IDLE) && !reset && !bus.flush && (|non_empty)) begin
            grant_valid = 1'b1;
            if (&non_empty) begin
                grant_src = ~last_grant_reg;
            end else begin
                grant_src = non_empty[SRC_SPI];
            end
        end
    end

    assign pop[SRC_NAT] = grant_valid && (grant_src == SRC_NAT);
    assign pop[SRC_SPI] = grant_valid && (grant_src == SRC_SPI);

    always_ff @(posedge clk27) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            gap_cnt_reg    <= '0;
            out_valid_reg  <= 1'b0;
            out_src_reg    <= SRC_NAT;
            last_grant_reg <= SRC_SPI;
        end else begin
            out_valid_reg <= 1'b0;
            if (bus.flush) begin
                state_reg   <= ST_IDLE;
                gap_cnt_reg <= '0;
            end else if (state_reg == ST_IDLE) begin
                if (grant_valid) begin
                    out_valid_reg  <= 1'b1;
                    out_src_reg    <= grant_src;
                    last_grant_reg <= grant_src;
                    state_reg      <= ST_GAP;
                    gap_cnt_reg    <= GAP_LOAD;
                end
            end else begin
                // Load of MIN_GAP-2 plus the IDLE/grant cycles spaces pulses by MIN_GAP.
                if (gap_cnt_reg == '0) begin
                    state_reg <= ST_IDLE;
                end else begin
                    gap_cnt_reg <= gap_cnt_reg - GAP_W'(1);
                end
            end
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_src   = out_src_reg;
    assign bus.out_data  = out_src_reg ? head_word[SRC_SPI] : head_word[SRC_NAT];
    assign bus.spi_drop  = drop[SRC_SPI];
    assign bus.nat_drop  = drop[SRC_NAT];
`ifdef KBD_ARB_DROP_CNT_EN
    assign bus.spi_drop_cnt = drop_cnt[SRC_SPI];
    assign bus.nat_drop_cnt = drop_cnt[SRC_NAT];
`endif
endmodule
